// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_responder
// Purpose  : AXI3 slave memory model. Word-addressed 64-bit memory answering
//            one INCR write burst and one INCR read burst at a time on
//            independent channels, with IDs echoed on B and R.
// Options  : AXI_RESP_ERR_EN - when defined, enables protocol/address checks
//            and SLVERR responses; when undefined, addresses wrap and
//            wid/wlast are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_responder #(
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3,
    parameter int MEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    // write address channel
    input  logic [ID_BITS-1:0]   awid,
    input  logic [31:0]          awaddr,
    input  logic [LEN_BITS-1:0]  awlen,
    input  logic [SIZE_BITS-1:0] awsize,
    input  logic                 awvalid,
    output logic                 awready,
    // write data channel
    input  logic [ID_BITS-1:0]   wid,
    input  logic [63:0]          wdata,
    input  logic [7:0]           wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    // write response channel
    output logic [ID_BITS-1:0]   bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    // read address channel
    input  logic [ID_BITS-1:0]   arid,
    input  logic [31:0]          araddr,
    input  logic [LEN_BITS-1:0]  arlen,
    input  logic [SIZE_BITS-1:0] arsize,
    input  logic                 arvalid,
    output logic                 arready,
    // read data channel
    output logic [ID_BITS-1:0]   rid,
    output logic [63:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready
);

    localparam int         c_IDX_BITS = $clog2(MEM_WORDS);
    localparam logic [1:0] c_OKAY     = 2'b00;
    localparam logic [1:0] c_SLVERR   = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Storage; deliberately not cleared by reset so contents survive a reset
    logic [63:0] r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    wstate_t               r_wstate;
    logic [ID_BITS-1:0]    r_wid;
    logic [31:0]           r_waddr;
    logic [LEN_BITS-1:0]   r_wlen;
    logic [SIZE_BITS-1:0]  r_wsize;
    logic [LEN_BITS-1:0]   r_wbeat;
    logic                  r_werr;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wbeat_last;
    logic [31:0]           w_wstep;
    logic [c_IDX_BITS-1:0] w_widx;
    logic                  w_waddr_bad;
    logic                  w_wbeat_err;
    logic                  w_mem_we;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    rstate_t               r_rstate;
    logic [31:0]           r_raddr;
    logic [LEN_BITS-1:0]   r_rlen;
    logic [SIZE_BITS-1:0]  r_rsize;
    logic [LEN_BITS-1:0]   r_rbeat;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [31:0]           w_rnext;
    logic [LEN_BITS-1:0]   w_rbeat_nxt;
    logic                  w_ar_bad;
    logic                  w_rnext_bad;

    assign w_aw_hs      = awvalid && awready;
    assign w_w_hs       = wvalid && wready;
    assign w_wbeat_last = (r_wbeat == r_wlen);
    assign w_wstep      = 32'd1 << r_wsize;
    assign w_widx       = r_waddr[3 +: c_IDX_BITS];

    assign w_ar_hs      = arvalid && arready;
    assign w_r_hs       = rvalid && rready;
    assign w_rnext      = r_raddr + (32'd1 << r_rsize);
    assign w_rbeat_nxt  = r_rbeat + 1'b1;

`ifdef AXI_RESP_ERR_EN
    // Any address bit above the memory span marks the beat out of range
    assign w_waddr_bad  = |r_waddr[31:c_IDX_BITS+3];
    assign w_ar_bad     = |araddr[31:c_IDX_BITS+3];
    assign w_rnext_bad  = |w_rnext[31:c_IDX_BITS+3];
    // Burst length follows awlen; wlast only has to agree with it
    assign w_wbeat_err  = (wid != r_wid) || (wlast != w_wbeat_last) || w_waddr_bad;
`else
    logic w_unused;
    assign w_waddr_bad  = 1'b0;
    assign w_ar_bad     = 1'b0;
    assign w_rnext_bad  = 1'b0;
    assign w_wbeat_err  = 1'b0;
    assign w_unused     = ^{wid, wlast};
`endif

    // Out-of-range beats are dropped; the write is also suppressed in reset
    assign w_mem_we = reset && w_w_hs && !w_waddr_bad;

    // Byte-lane write of the current beat into the memory array
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Write burst FSM: address capture, beat sequencing, sticky error, B response
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wbeat  <= '0;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wid    <= awid;
                        r_waddr  <= awaddr;
                        r_wlen   <= awlen;
                        r_wsize  <= awsize;
                        r_wbeat  <= '0;
                        r_werr   <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        r_wstate <= W_DATA;
                    end else begin
                        awready  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_werr  <= r_werr | w_wbeat_err;
                        r_waddr <= r_waddr + w_wstep;
                        r_wbeat <= r_wbeat + 1'b1;
                        if (w_wbeat_last) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= r_wid;
                            bresp    <= (r_werr || w_wbeat_err) ? c_SLVERR : c_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Read burst FSM: registered R payload, refetched from memory after each handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rbeat  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr  <= araddr;
                        r_rlen   <= arlen;
                        r_rsize  <= arsize;
                        r_rbeat  <= '0;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= arid;
                        rlast    <= (arlen == '0);
                        rdata    <= w_ar_bad ? 64'd0 : r_mem[araddr[3 +: c_IDX_BITS]];
                        rresp    <= w_ar_bad ? c_SLVERR : c_OKAY;
                        r_rstate <= R_DATA;
                    end else begin
                        arready  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_raddr <= w_rnext;
                            r_rbeat <= w_rbeat_nxt;
                            rlast   <= (w_rbeat_nxt == r_rlen);
                            rdata   <= w_rnext_bad ? 64'd0 : r_mem[w_rnext[3 +: c_IDX_BITS]];
                            rresp   <= w_rnext_bad ? c_SLVERR : c_OKAY;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_responder
// Purpose  : Self-checking bench for axi_mem_responder: table of write/read
//            burst pairs plus hand sequences for reset, backpressure,
//            reset mid-burst and (with AXI_RESP_ERR_EN) error responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;

    localparam int ID_BITS   = 4;
    localparam int LEN_BITS  = 4;
    localparam int SIZE_BITS = 3;
    localparam int MEM_WORDS = 1024;
    localparam int CYC       = 50;

    typedef logic [3:0][63:0] beats_t;
    typedef logic [3:0][7:0]  strbs_t;
    typedef logic [3:0][1:0]  resps_t;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  wlen;
        logic [2:0]  wsize;
        logic [3:0]  w_id;
        beats_t      wd;
        strbs_t      ws;
        logic [31:0] raddr;
        logic [3:0]  rlen;
        logic [2:0]  rsize;
        logic [3:0]  r_id;
        beats_t      rexp;
    } vec_t;

    logic                 clk;
    logic                 reset;
    logic [ID_BITS-1:0]   awid;
    logic [31:0]          awaddr;
    logic [LEN_BITS-1:0]  awlen;
    logic [SIZE_BITS-1:0] awsize;
    logic                 awvalid;
    logic                 awready;
    logic [ID_BITS-1:0]   wid;
    logic [63:0]          wdata;
    logic [7:0]           wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;
    logic [ID_BITS-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ID_BITS-1:0]   arid;
    logic [31:0]          araddr;
    logic [LEN_BITS-1:0]  arlen;
    logic [SIZE_BITS-1:0] arsize;
    logic                 arvalid;
    logic                 arready;
    logic [ID_BITS-1:0]   rid;
    logic [63:0]          rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    int n_pass;
    int n_total;

    axi_mem_responder #(
        .ID_BITS   (ID_BITS),
        .LEN_BITS  (LEN_BITS),
        .SIZE_BITS (SIZE_BITS),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One write burst; early_last >= 0 raises wlast on that beat instead of the final one
    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [3:0] id, input beats_t d, input strbs_t s,
                            input int early_last, input int bdelay, input logic [1:0] exp_bresp);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
        n = 0;
        while (!awready && n < CYC) begin @(negedge clk); n++; end
        chk("aw_wait_awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("aw_then_awready_low", awready, 0);
        chk("aw_then_wready_high", wready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            wid = id; wdata = d[b]; wstrb = s[b]; wvalid = 1'b1;
            wlast = (early_last >= 0) ? (b == early_last) : (b == int'(len));
            chk("w_beat_wready", wready, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_bvalid", bvalid, 1);
        chk("b_wready_low", wready, 0);
        chk("b_bid", bid, id);
        chk("b_bresp", bresp, exp_bresp);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            chk("b_hold_bvalid", bvalid, 1);
            chk("b_hold_bid", bid, id);
            chk("b_hold_bresp", bresp, exp_bresp);
            chk("b_hold_awready_low", awready, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done_bvalid_low", bvalid, 0);
        chk("b_done_awready", awready, 1);
    endtask

    // One read burst; toggle alternates rready 0/1 starting with 0
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [3:0] id, input beats_t exp, input resps_t eresp,
                           input bit toggle);
        int n;
        int idx;
        bit ph;
        logic rr;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
        n = 0;
        while (!arready && n < CYC) begin @(negedge clk); n++; end
        chk("ar_wait_arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_then_arready_low", arready, 0);
        idx = 0; n = 0; ph = 1'b0;
        while (idx <= int'(len) && n < CYC) begin
            chk("r_rvalid", rvalid, 1);
            chk("r_rdata", rdata, exp[idx]);
            chk("r_rid", rid, id);
            chk("r_rresp", rresp, eresp[idx]);
            chk("r_rlast", rlast, (idx == int'(len)) ? 1 : 0);
            rr = toggle ? ph : 1'b1;
            ph = !ph;
            rready = rr;
            @(negedge clk);
            if (rr) idx++;
            n++;
        end
        rready = 1'b0;
        chk("r_all_beats_taken", idx, int'(len) + 1);
        chk("r_done_rvalid_low", rvalid, 0);
        chk("r_done_arready", arready, 1);
    endtask

    vec_t vecs [7];

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;

        vecs[0] = '{32'h100, 4'd3, 3'd3, 4'd5,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'hFFFF_FFFF,
                    32'h100, 4'd3, 3'd3, 4'd2,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{32'h200, 4'd0, 3'd3, 4'd1, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 32'h0000_00FF,
                    32'h200, 4'd0, 3'd3, 4'd3, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[2] = '{32'h200, 4'd0, 3'd3, 4'd4, {192'h0, 64'h0}, 32'h0000_000F,
                    32'h200, 4'd0, 3'd3, 4'd6, {192'h0, 64'hFFFF_FFFF_0000_0000}};
        vecs[3] = '{32'h3F8, 4'd1, 3'd3, 4'd7,
                    {128'h0, 64'h5A5A_0000_0000_0002, 64'hA5A5_0000_0000_0001}, 32'h0000_FFFF,
                    32'h3F8, 4'd1, 3'd3, 4'd9,
                    {128'h0, 64'h5A5A_0000_0000_0002, 64'hA5A5_0000_0000_0001}};
        vecs[4] = '{32'h500, 4'd1, 3'd2, 4'd8,
                    {128'h0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 32'h0000_F00F,
                    32'h500, 4'd0, 3'd3, 4'd10, {192'h0, 64'hFEDC_BA98_89AB_CDEF}};
        vecs[5] = '{32'h600, 4'd2, 3'd3, 4'd11,
                    {64'h0, 64'h0606_0000_0000_0003, 64'h0606_0000_0000_0002, 64'h0606_0000_0000_0001},
                    32'h00FF_FFFF,
                    32'h500, 4'd1, 3'd2, 4'd12,
                    {128'h0, 64'hFEDC_BA98_89AB_CDEF, 64'hFEDC_BA98_89AB_CDEF}};
        vecs[6] = '{32'h700, 4'd0, 3'd3, 4'd13, {192'h0, 64'hDEAD_BEEF_CAFE_F00D}, 32'h0000_00FF,
                    32'h600, 4'd2, 3'd3, 4'd14,
                    {64'h0, 64'h0606_0000_0000_0003, 64'h0606_0000_0000_0002, 64'h0606_0000_0000_0001}};

        // Reset state, then first cycle after release
        repeat (3) @(negedge clk);
        chk("rst_ready_valids", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
        chk("rst_bid_bresp", {bid, bresp}, 6'b0);
        chk("rst_rid_rresp", {rid, rresp}, 6'b0);
        chk("rst_rdata", rdata, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        // Table of write/read pairs
        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].waddr, vecs[v].wlen, vecs[v].wsize, vecs[v].w_id,
                     vecs[v].wd, vecs[v].ws, -1, 0, 2'b00);
            do_read(vecs[v].raddr, vecs[v].rlen, vecs[v].rsize, vecs[v].r_id,
                    vecs[v].rexp, '0, 1'b0);
        end
        do_read(32'h700, 4'd0, 3'd3, 4'd15, {192'h0, 64'hDEAD_BEEF_CAFE_F00D}, '0, 1'b0);

        // Backpressure on B and R
        do_write(32'h800, 4'd3, 3'd3, 4'd6,
                 {64'hD4, 64'hC3, 64'hB2, 64'hA1}, 32'hFFFF_FFFF, -1, 5, 2'b00);
        do_read(32'h800, 4'd3, 3'd3, 4'd1, {64'hD4, 64'hC3, 64'hB2, 64'hA1}, '0, 1'b1);

        // Reset asserted after the 2nd of 4 write beats
        @(negedge clk);
        awid = 4'd3; awaddr = 32'hA00; awlen = 4'd3; awsize = 3'd3; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wid = 4'd3; wdata = 64'hBAD0 + 64'(b); wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_wready_low", wready, 0);
        chk("midrst_bvalid_low", bvalid, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rel_bvalid_low", bvalid, 0);
        chk("midrst_rel_awready", awready, 1);
        do_write(32'hA00, 4'd3, 3'd3, 4'd4,
                 {64'h0A03, 64'h0A02, 64'h0A01, 64'h0A00}, 32'hFFFF_FFFF, -1, 0, 2'b00);
        do_read(32'hA00, 4'd3, 3'd3, 4'd5, {64'h0A03, 64'h0A02, 64'h0A01, 64'h0A00}, '0, 1'b0);

`ifdef AXI_RESP_ERR_EN
        // wlast on beat 0 of a 2-beat burst is a protocol error
        do_write(32'h900, 4'd1, 3'd3, 4'd2, {128'h0, 64'h2, 64'h1}, 32'h0000_FFFF, 0, 0, 2'b10);
        // Burst crossing the top of memory: only the out-of-range beat errors
        do_write(32'h1FF8, 4'd0, 3'd3, 4'd1, {192'h0, 64'h1FF8_1FF8_1FF8_1FF8}, 32'h0000_00FF,
                 -1, 0, 2'b00);
        do_read(32'h1FF8, 4'd1, 3'd3, 4'd7, {128'h0, 64'h0, 64'h1FF8_1FF8_1FF8_1FF8},
                {4'b0, 2'b10, 2'b00}, 1'b0);
        do_read(32'(MEM_WORDS * 8), 4'd0, 3'd3, 4'd8, '0, {6'b0, 2'b10}, 1'b0);
`else
        // Without checks, addresses wrap modulo the memory size
        do_write(32'(MEM_WORDS * 8) + 32'h20, 4'd0, 3'd3, 4'd2, {192'h0, 64'h0123_0000_2020_0001},
                 32'h0000_00FF, -1, 0, 2'b00);
        do_read(32'h20, 4'd0, 3'd3, 4'd3, {192'h0, 64'h0123_0000_2020_0001}, '0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
